// File: rtl/bsg_manycore_ret_responder.sv
// Return-network responder: passes forward packets to the proc and queues one ack per accepted store.
// Optional BSG_MANYCORE_RET_ERR_EN: unknown ops also return an error ack so initiators never hang.
module bsg_manycore_ret_responder #(
   parameter int unsigned x_cord_width_p = 5,
   parameter int unsigned y_cord_width_p = 5,
   parameter int unsigned addr_width_p   = 32,
   parameter int unsigned data_width_p   = 32,
   parameter int unsigned fifo_els_p     = 4,
   localparam int unsigned packet_width_lp     = 6 + 2*(x_cord_width_p + y_cord_width_p)
                                                 + addr_width_p + data_width_p,
   localparam int unsigned ret_packet_width_lp = x_cord_width_p + y_cord_width_p + 5,
   localparam int unsigned pending_width_lp    = $clog2(fifo_els_p + 1)
) (
   input  logic                           clk_i,
   input  logic                           reset_i,
   input  logic                           v_i,
   input  logic [packet_width_lp-1:0]     data_i,
   output logic                           ready_o,
   output logic                           v_o,
   output logic [packet_width_lp-1:0]     data_o,
   input  logic                           ready_i,
   output logic                           ret_v_o,
   output logic [ret_packet_width_lp-1:0] ret_data_o,
   input  logic                           ret_ready_i,
   output logic [pending_width_lp-1:0]    pending_o
);

   localparam int unsigned ptr_width_lp   = $clog2(fifo_els_p);
   localparam int unsigned entry_width_lp = x_cord_width_p + y_cord_width_p + 2;

   typedef enum logic [0:0] {ST_EMPTY, ST_HOLD} state_e;

   state_e                          state_q, state_d;
   logic [ptr_width_lp-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [pending_width_lp-1:0]     count_q, count_d;
   logic [ret_packet_width_lp-1:0]  ret_data_q, ret_data_d;
   logic [entry_width_lp-1:0]       mem_q [fifo_els_p];

   logic [5:0]                      op;
   logic [x_cord_width_p-1:0]       from_x;
   logic [y_cord_width_p-1:0]       from_y;
   logic                            is_store, is_err, ack_needed, full, space_ok, enq, deq;
   logic [entry_width_lp-1:0]       new_entry;

   // Forward-packet decode and flow control (full gating uses the registered count only)
   assign op       = data_i[packet_width_lp-1 -: 6];
   assign from_x   = data_i[x_cord_width_p + y_cord_width_p +: x_cord_width_p];
   assign from_y   = data_i[2*x_cord_width_p + y_cord_width_p +: y_cord_width_p];
   assign is_store = (op == 6'h01);
`ifdef BSG_MANYCORE_RET_ERR_EN
   assign is_err   = (op != 6'h01) && (op != 6'h02);
`else
   assign is_err   = 1'b0;
`endif
   assign ack_needed = is_store | is_err;
   assign full       = (count_q == pending_width_lp'(fifo_els_p));
   assign space_ok   = ~ack_needed | ~full;
   assign v_o        = v_i & space_ok;
   assign ready_o    = ready_i & space_ok;
   assign data_o     = data_i;

   assign enq       = v_i & ready_o & ack_needed;
   assign deq       = (state_q == ST_HOLD) & ret_ready_i;
   assign new_entry = {from_y, from_x, is_store, is_err};

   always_comb begin
      wr_ptr_d   = wr_ptr_q + ptr_width_lp'(enq);
      rd_ptr_d   = rd_ptr_q + ptr_width_lp'(deq);
      count_d    = count_q + pending_width_lp'(enq) - pending_width_lp'(deq);
      state_d    = state_q;
      ret_data_d = '0;

      case (state_q)
         ST_EMPTY: if (enq) state_d = ST_HOLD;
         ST_HOLD:  if (deq && (count_q == pending_width_lp'(1)) && !enq) state_d = ST_EMPTY;
         default:  state_d = ST_EMPTY;
      endcase

      // Next head: the entry being written if it lands in an otherwise-empty queue
      if (state_d == ST_HOLD) begin
         if (count_q == pending_width_lp'(deq))
            ret_data_d = {1'b1, new_entry, 2'b00};
         else
            ret_data_d = {1'b1, mem_q[rd_ptr_d], 2'b00};
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q    <= ST_EMPTY;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ret_data_q <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ret_data_q <= ret_data_d;
      end
   end

   // Ack storage; occupancy is tracked by count_q so contents need no reset
   always_ff @(posedge clk_i) begin
      if (enq) mem_q[wr_ptr_q] <= new_entry;
   end

   assign ret_v_o    = (state_q == ST_HOLD);
   assign ret_data_o = ret_data_q;
   assign pending_o  = count_q;

endmodule
